// File: rtl/muldiv_pkg.sv
// Shared encodings and sizing helper for the HI/LO multiply/divide engine.
package muldiv_pkg;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5
  } op_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } state_e;

  // Counter width for an iteration count n; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration: shift-add for multiply, restoring trial-subtract for divide.
module muldiv_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             i_is_div,
  input  logic [WIDTH-1:0] i_hi,
  input  logic [WIDTH-1:0] i_lo,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo
);

  logic [WIDTH:0] w_sum;
  logic [WIDTH:0] w_shift;
  logic           w_ge;

  always_comb begin
    w_sum   = {1'b0, i_hi} + (i_lo[0] ? {1'b0, i_b} : '0);
    w_shift = {i_hi, i_lo[WIDTH-1]};
    w_ge    = (w_shift >= {1'b0, i_b});
    if (i_is_div) begin
      // Partial remainder stays below the divisor, so it always fits WIDTH bits.
      o_hi = w_ge ? WIDTH'(w_shift - {1'b0, i_b}) : w_shift[WIDTH-1:0];
      o_lo = {i_lo[WIDTH-2:0], w_ge};
    end else begin
      o_hi = w_sum[WIDTH:1];
      o_lo = {w_sum[0], i_lo[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/hi_lo_muldiv_unit.sv
// Iterative multiply/divide engine owning the architectural HI/LO registers.
module hi_lo_muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH           = 32,
  parameter int unsigned STEPS_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clk_enable,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned N  = WIDTH / STEPS_PER_CYCLE;
  localparam int unsigned CW = cnt_width(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  if (STEPS_PER_CYCLE == 0 || (WIDTH % STEPS_PER_CYCLE) != 0) begin : g_bad_cfg
    $error("hi_lo_muldiv_unit: STEPS_PER_CYCLE must divide WIDTH exactly");
  end

  state_e           r_state, w_state_next;
  logic             w_accept, w_mt_write, w_iterate, w_finish, w_last;
  logic             r_busy, r_done, r_is_div, r_neg_q, r_neg_r, r_div_zero;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_hi, r_lo, r_acc_hi, r_acc_lo, r_b;
  logic             w_a_neg, w_b_neg;
  logic [WIDTH-1:0] w_mag_a, w_mag_b, w_res_hi, w_res_lo;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0] w_hi [0:STEPS_PER_CYCLE];
  logic [WIDTH-1:0] w_lo [0:STEPS_PER_CYCLE];

  assign busy = r_busy;
  assign done = r_done;
  assign hi   = r_hi;
  assign lo   = r_lo;

  // Sequencer next-state and control strobes.
  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_mt_write   = 1'b0;
    w_iterate    = 1'b0;
    w_finish     = 1'b0;
    w_last       = (r_cnt == LAST);
    case (r_state)
      IDLE: begin
        if (start && !flush) begin
          if (!op[2]) begin
            w_accept     = 1'b1;
            w_state_next = RUN;
          end else if (!op[1]) begin
            w_mt_write = 1'b1;
          end
        end
      end
      RUN: begin
        if (flush) begin
          w_state_next = IDLE;
        end else begin
          w_iterate = 1'b1;
          if (w_last) w_state_next = FINISH;
        end
      end
      FINISH: begin
        w_finish     = !flush;
        w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)           r_state <= IDLE;
    else if (clk_enable) r_state <= w_state_next;
  end

  // Signed ops (even op codes) run on magnitudes; signs are restored at FINISH.
  always_comb begin
    w_a_neg = !op[0] && operand_a[WIDTH-1];
    w_b_neg = !op[0] && operand_b[WIDTH-1];
    w_mag_a = w_a_neg ? -operand_a : operand_a;
    w_mag_b = w_b_neg ? -operand_b : operand_b;
  end

  assign w_hi[0] = r_acc_hi;
  assign w_lo[0] = r_acc_lo;

  for (genvar g = 0; g < STEPS_PER_CYCLE; g++) begin : g_step
    muldiv_step #(.WIDTH(WIDTH)) u_step (
      .i_is_div (r_is_div),
      .i_hi     (w_hi[g]),
      .i_lo     (w_lo[g]),
      .i_b      (r_b),
      .o_hi     (w_hi[g+1]),
      .o_lo     (w_lo[g+1])
    );
  end

  // Result formatting: divide-by-zero forces an all-ones quotient.
  always_comb begin
    w_prod = {r_acc_hi, r_acc_lo};
    if (r_neg_q) w_prod = -w_prod;
    if (r_is_div) begin
      w_res_hi = r_neg_r ? -r_acc_hi : r_acc_hi;
      w_res_lo = r_div_zero ? '1 : (r_neg_q ? -r_acc_lo : r_acc_lo);
    end else begin
      w_res_hi = w_prod[2*WIDTH-1:WIDTH];
      w_res_lo = w_prod[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_hi       <= '0;
      r_lo       <= '0;
      r_cnt      <= '0;
      r_acc_hi   <= '0;
      r_acc_lo   <= '0;
      r_b        <= '0;
      r_is_div   <= 1'b0;
      r_neg_q    <= 1'b0;
      r_neg_r    <= 1'b0;
      r_div_zero <= 1'b0;
    end else if (clk_enable) begin
      r_busy <= (w_state_next != IDLE);
      r_done <= w_finish;
      if (w_accept) begin
        r_cnt      <= '0;
        r_is_div   <= op[1];
        r_neg_q    <= w_a_neg ^ w_b_neg;
        r_neg_r    <= w_a_neg;
        r_div_zero <= op[1] && (operand_b == '0);
        r_acc_hi   <= '0;
        r_acc_lo   <= op[1] ? w_mag_a : w_mag_b;
        r_b        <= op[1] ? w_mag_b : w_mag_a;
      end else if (w_iterate) begin
        r_acc_hi <= w_hi[STEPS_PER_CYCLE];
        r_acc_lo <= w_lo[STEPS_PER_CYCLE];
        if (!w_last) r_cnt <= r_cnt + CW'(1);
      end
      if (w_finish) begin
        r_hi <= w_res_hi;
        r_lo <= w_res_lo;
      end else if (w_mt_write) begin
        if (op[0]) r_lo <= operand_a;
        else       r_hi <= operand_a;
      end
    end
  end

endmodule

// File: tb/tb_hi_lo_muldiv_unit.sv
// Self-checking bench for hi_lo_muldiv_unit: vector table, scoreboard and corner sequences.
module tb_hi_lo_muldiv_unit;
  import muldiv_pkg::*;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] eh;
    logic [31:0] el;
    string       name;
  } vec_t;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset, clk_enable, start, flush;
  logic [2:0]  op;
  logic [31:0] operand_a, operand_b, hi, lo;
  logic        busy, done;
  logic        start4;
  logic [2:0]  op4;
  logic [31:0] a4, b4, hi4, lo4;
  logic        busy4, done4;

  int n_checks = 0;
  int n_fail   = 0;
  exp_t sb_q[$];
  vec_t vecs[12];

  always #5 clk = ~clk;

  hi_lo_muldiv_unit dut (
    .clk(clk), .reset(reset), .clk_enable(clk_enable), .start(start), .op(op),
    .operand_a(operand_a), .operand_b(operand_b), .flush(flush),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  hi_lo_muldiv_unit #(.WIDTH(32), .STEPS_PER_CYCLE(4)) dut4 (
    .clk(clk), .reset(reset), .clk_enable(clk_enable), .start(start4), .op(op4),
    .operand_a(a4), .operand_b(b4), .flush(flush),
    .busy(busy4), .done(done4), .hi(hi4), .lo(lo4)
  );

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Counts edges after the accept edge until done is seen; optional 5-cycle enable drop.
  task automatic wait_done(output int lat, output int busy_n, input int stall_at);
    lat = 0;
    busy_n = 0;
    while (!done && lat < 300) begin
      if (busy) busy_n++;
      if (stall_at >= 0) clk_enable = !(lat >= stall_at && lat < stall_at + 5);
      @(negedge clk);
      lat++;
    end
    clk_enable = 1'b1;
  endtask

  task automatic pop_check(input string nm);
    exp_t e;
    if (sb_q.size() == 0) begin
      check({nm, "_sb_empty"}, 64'd1, 64'd0);
    end else begin
      e = sb_q.pop_front();
      check({nm, "_hi"}, hi, e.hi);
      check({nm, "_lo"}, lo, e.lo);
    end
  endtask

  task automatic do_md(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] eh, input logic [31:0] el, input string nm,
                       input int exp_lat, input int stall_at);
    int lat, bn;
    @(negedge clk);
    start = 1'b1; op = o; operand_a = a; operand_b = b;
    sb_q.push_back('{hi: eh, lo: el});
    @(negedge clk);
    start = 1'b0; op = 3'd7;
    wait_done(lat, bn, stall_at);
    check({nm, "_latency"}, lat, exp_lat);
    check({nm, "_busy_cycles"}, bn, exp_lat);
    pop_check(nm);
    @(negedge clk);
    check({nm, "_done_pulse"}, done, 1'b0);
  endtask

  task automatic mt_write(input logic [2:0] o, input logic [31:0] d);
    @(negedge clk);
    start = 1'b1; op = o; operand_a = d;
    @(negedge clk);
    start = 1'b0; op = 3'd7;
  endtask

  initial begin
    int lat, bn, seen;
    vecs[0]  = '{3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, "multu_max"};
    vecs[1]  = '{3'd0, 32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB, "mult_neg3x7"};
    vecs[2]  = '{3'd0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, "mult_minxmin"};
    vecs[3]  = '{3'd2, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, "div_neg7by2"};
    vecs[4]  = '{3'd3, 32'd7,        32'd0,        32'd7,        32'hFFFFFFFF, "divu_by0"};
    vecs[5]  = '{3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, "div_min_by_m1"};
    vecs[6]  = '{3'd3, 32'd100,      32'd7,        32'd2,        32'd14,       "divu_100by7"};
    vecs[7]  = '{3'd1, 32'd3,        32'd5,        32'd0,        32'd15,       "multu_3x5"};
    vecs[8]  = '{3'd2, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, "div_7byneg2"};
    vecs[9]  = '{3'd2, 32'hFFFFFFF8, 32'd0,        32'hFFFFFFF8, 32'hFFFFFFFF, "div_neg8by0"};
    vecs[10] = '{3'd0, 32'h12345678, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hEDCBA988, "mult_byneg1"};
    vecs[11] = '{3'd3, 32'hFFFFFFFF, 32'd10,       32'h00000005, 32'h19999999, "divu_max_by10"};

    reset = 1'b1; clk_enable = 1'b1; start = 1'b0; flush = 1'b0; op = 3'd7;
    operand_a = '0; operand_b = '0; start4 = 1'b0; op4 = 3'd7; a4 = '0; b4 = '0;
    #2;
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    foreach (vecs[i])
      do_md(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].eh, vecs[i].el, vecs[i].name, 33, -1);

    // MTHI / MTLO write immediately with no busy or done.
    @(negedge clk);
    start = 1'b1; op = OP_MTHI; operand_a = 32'h1234;
    @(negedge clk);
    start = 1'b0; op = 3'd7;
    check("mthi_hi", hi, 32'h1234);
    check("mthi_busy", busy, 1'b0);
    check("mthi_done", done, 1'b0);
    mt_write(OP_MTLO, 32'h4321);
    check("mtlo_lo", lo, 32'h4321);

    // MTLO issued while busy is ignored.
    @(negedge clk);
    start = 1'b1; op = OP_MULTU; operand_a = 32'd3; operand_b = 32'd5;
    sb_q.push_back('{hi: 32'd0, lo: 32'd15});
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    start = 1'b1; op = OP_MTLO; operand_a = 32'hAAAA;
    @(negedge clk);
    start = 1'b0; op = 3'd7;
    check("ignore_lo_mid", lo, 32'h4321);
    wait_done(lat, bn, -1);
    check("ignore_latency", lat, 28);
    pop_check("ignore_final");

    // Flush mid-RUN discards the op and leaves HI/LO alone.
    mt_write(OP_MTHI, 32'h5555);
    mt_write(OP_MTLO, 32'h6666);
    @(negedge clk);
    start = 1'b1; op = OP_MULTU; operand_a = 32'd3; operand_b = 32'd5;
    @(negedge clk);
    start = 1'b0; op = 3'd7;
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_busy", busy, 1'b0);
    check("flush_done", done, 1'b0);
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) seen = 1;
    end
    check("flush_no_done", seen, 0);
    check("flush_hi", hi, 32'h5555);
    check("flush_lo", lo, 32'h6666);
    // Flush in IDLE blocks a same-cycle start.
    @(negedge clk);
    start = 1'b1; flush = 1'b1; op = OP_MTHI; operand_a = 32'h9;
    @(negedge clk);
    op = OP_DIVU;
    @(negedge clk);
    start = 1'b0; flush = 1'b0; op = 3'd7;
    check("idle_flush_hi", hi, 32'h5555);
    check("idle_flush_busy", busy, 1'b0);
    do_md(OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, "after_flush", 33, -1);

    // clk_enable low for 5 cycles mid-RUN stretches latency by 5.
    do_md(OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, "stall", 38, 10);

    // done holds while disabled; a start in the done cycle is accepted.
    @(negedge clk);
    start = 1'b1; op = OP_MULTU; operand_a = 32'd2; operand_b = 32'd3;
    sb_q.push_back('{hi: 32'd0, lo: 32'd6});
    @(negedge clk);
    start = 1'b0; op = 3'd7;
    wait_done(lat, bn, -1);
    pop_check("b2b_first");
    clk_enable = 1'b0;
    repeat (3) @(negedge clk);
    check("done_hold", done, 1'b1);
    clk_enable = 1'b1;
    start = 1'b1; op = OP_MULTU; operand_a = 32'd4; operand_b = 32'd5;
    sb_q.push_back('{hi: 32'd0, lo: 32'd20});
    @(negedge clk);
    start = 1'b0; op = 3'd7;
    check("b2b_accept_busy", busy, 1'b1);
    check("b2b_done_clear", done, 1'b0);
    wait_done(lat, bn, -1);
    check("b2b_latency", lat, 33);
    pop_check("b2b_second");

    // Asynchronous reset mid-RUN clears everything without a clock edge.
    mt_write(OP_MTHI, 32'h77);
    mt_write(OP_MTLO, 32'h88);
    @(negedge clk);
    start = 1'b1; op = OP_MULTU; operand_a = 32'd3; operand_b = 32'd5;
    @(negedge clk);
    start = 1'b0; op = 3'd7;
    repeat (9) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("arst_busy", busy, 1'b0);
    check("arst_done", done, 1'b0);
    check("arst_hi", hi, 32'd0);
    check("arst_lo", lo, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) seen = 1;
    end
    check("arst_no_done", seen, 0);

    // Four iterations per clock: 8 run cycles plus FINISH.
    @(negedge clk);
    start4 = 1'b1; op4 = OP_MULTU; a4 = 32'd6; b4 = 32'd7;
    @(negedge clk);
    start4 = 1'b0; op4 = 3'd7;
    lat = 0;
    while (!done4 && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    check("steps4_latency", lat, 9);
    check("steps4_lo", lo4, 32'd42);
    check("steps4_hi", hi4, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hi_lo_muldiv_unit.md
Name: hi_lo_muldiv_unit

Overview:
- Parametrised iterative multiply/divide engine that owns the architectural HI and LO registers of the pipelined CPU.
- Executes MULT, MULTU, DIV, DIVU, MTHI and MTLO.
- Replaces single-cycle HI/LO ALU outputs; sits beside the execute-stage ALU.
- The hazard unit stalls issue of a dependent MFHI/MFLO or another mult/div op while busy=1.

Parameters:
- WIDTH, 32, operand and HI/LO width.
- STEPS_PER_CYCLE, 1, radix-2 iterations per clock. Must divide WIDTH exactly; elaboration error otherwise.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- clk_enable  in  1  when 0, all state frozen; no outputs change.
- start  in  1  request; sampled only in IDLE.
- op  in  3  operation: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6-7 no-op.
- operand_a  in  WIDTH  multiplicand / dividend / MTHI-MTLO data.
- operand_b  in  WIDTH  multiplier / divisor.
- flush  in  1  abort in-flight operation.
- busy  out  1  high while RUN or FINISH.
- done  out  1  one-cycle pulse when HI/LO updated by a mult/div.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

Behaviour:
- Reset (async, immediate): state=IDLE, hi=0, lo=0, busy=0, done=0, iteration counter=0. Reset mid-operation discards the operation with no done pulse.
- States:
  - IDLE -> RUN on start with op 0-3.
  - RUN -> FINISH after N=WIDTH/STEPS_PER_CYCLE enabled cycles.
  - FINISH -> IDLE after one cycle.
- Latency:
  - The start-accept edge loads operands into RUN and sets busy=1.
  - N edges perform the iterations.
  - The next edge writes hi/lo, sets done=1, busy=0, state=IDLE.
  - Result is visible N+1 edges after the accept edge: 33 for defaults.
- MTHI/MTLO in IDLE with start=1: hi (resp. lo) takes operand_a on that edge. busy stays 0 and done stays 0.
- start while busy: ignored, any op. Operands are captured only at accept.
- start in the cycle done=1 is accepted, since state is already IDLE.
- Signed ops: take magnitudes at accept and record the sign flags. Sign correction is applied in FINISH.
- Multiply: shift-add on a 2*WIDTH product. {hi,lo} = full product.
- Divide: restoring division. lo = quotient truncated toward zero; hi = remainder with the sign of the dividend.
- Divide by zero (operand_b==0, DIV or DIVU): hi=operand_a, lo=all ones. Full N+1 latency is kept.
- DIV of most-negative by -1: lo=most-negative, hi=0. No trap.
- flush: in RUN or FINISH, next edge returns to IDLE with busy=0 and done=0; hi/lo unchanged. flush in IDLE has no effect and also blocks a same-cycle start.
- clk_enable=0: counter, state and registers hold. done, if high, stays high until the next enabled edge.
- The counter wraps only via reset to 0 on accept. It never exceeds N-1.

Decomposition:
- Shared package muldiv_pkg:
  - op encoding enum (MULT..MTLO)
  - state enum (IDLE, RUN, FINISH)
  - localparam N width helper via $clog2
- Sub-module muldiv_step: combinational single radix-2 iteration covering both the add-shift step (multiply) and the trial-subtract step (divide). Instantiated STEPS_PER_CYCLE times in a chain inside hi_lo_muldiv_unit; the sequencing FSM lives in the parent.

Test Plan:
- MULTU 0xFFFFFFFF x 0xFFFFFFFF -> after 33 edges hi=0xFFFFFFFE, lo=0x00000001; done high exactly one cycle; busy high for 32+1 cycles.
- MULT 0xFFFFFFFD (-3) x 7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB. MULT 0x80000000 x 0x80000000 -> hi=0x40000000, lo=0.
- DIV 0xFFFFFFF9 (-7) / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 7 / 0 -> hi=7, lo=0xFFFFFFFF. DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- MTHI 0x1234 in IDLE -> hi=0x1234 next edge, busy=0. MULTU 3x5 started, then start+MTLO 0xAAAA at cycle 5 -> ignored; final lo=15, hi=0.
- MULTU 3x5 with flush at cycle 10 -> busy=0 next edge, no done, hi/lo keep prior values. Then DIVU 100/7 -> lo=14, hi=2.
- Async reset mid-RUN -> busy, done, hi, lo all 0 without a clock edge. With STEPS_PER_CYCLE=4, MULTU 6x7 -> done after 9 edges, lo=42. clk_enable low 5 cycles mid-RUN -> latency extends by exactly 5.
